read_return_queue: RTL

Parametrised, multi-entry tagged read-return buffer that replaces the single-entry read data register between the DDR4 command FSM and `send_read_data`. It captures each completed read burst together with its 3-bit request tag and returns entries in order to the cache-side transmitter over a valid/ready handshake. It also reports occupancy and raises `almost_full` so the Scheduler can stop issuing reads before returned data is lost.

---
 rtl/read_return_queue_if.sv | 39 +++
 rtl/read_return_queue.sv | 116 +++++++++++
 2 files changed

// File: rtl/read_return_queue_if.sv
// read_return_queue_if
//   Bundles the read-return queue's push side, pop side and status signals.
//   slave  : the queue itself (consumes push/out_ready, drives everything else)
//   master : the environment (FSM push side + transmitter + scheduler)
//   Signals:
//     push, push_data, push_tag   burst capture from the DDR4 command FSM
//     out_valid, out_ready        head handshake toward the transmitter
//     out_data, out_tag           head entry (zero while out_valid is low)
//     full, almost_full, count    occupancy status (registered state only)
//     overflow                    sticky dropped-push flag
interface read_return_queue_if #(
    parameter int DATAWIDTH = 512,
    parameter int TWIDTH    = 3,
    parameter int DEPTH     = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 push;
    logic [DATAWIDTH-1:0] push_data;
    logic [TWIDTH-1:0]    push_tag;
    logic                 full;
    logic                 almost_full;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] out_data;
    logic [TWIDTH-1:0]    out_tag;
    logic [CW-1:0]        count;
    logic                 overflow;

    modport slave (
        input  push, push_data, push_tag, out_ready,
        output full, almost_full, out_valid, out_data, out_tag, count, overflow
    );

    modport master (
        output push, push_data, push_tag, out_ready,
        input  full, almost_full, out_valid, out_data, out_tag, count, overflow
    );
endinterface

// File: rtl/read_return_queue.sv
// read_return_queue
//   Multi-entry tagged read-return buffer between the DDR4 command FSM and
//   send_read_data. Completed bursts are stored with their request tag in a
//   circular array and returned strictly in order over a valid/ready
//   handshake. Occupancy, full and almost_full are derived from registered
//   state so the scheduler's throttle has no combinational path from push
//   or out_ready.
//   Ports:
//     clock  sole clock, rising edge
//     reset  synchronous, active-high; clears pointers, count and overflow
//     rq     read_return_queue_if.slave (push side, pop side, status)
//   Optional build macro READQ_BYPASS_EN: when defined, a push into an empty
//   queue is presented on the output in the same cycle; if it is accepted
//   that cycle it is never written into storage.
module read_return_queue #(
    parameter int DATAWIDTH   = 512,
    parameter int TWIDTH      = 3,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic               clock,
    input  logic               reset,
    read_return_queue_if.slave rq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATAWIDTH + TWIDTH;

    // Storage is intentionally not reset; pointers/count define validity.
    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          stored_valid;
    logic          full;
    logic          pop;
    logic          byp_take;
    logic          wr_en;
    logic [EW-1:0] head;

    assign stored_valid = (count_q != '0);
    assign full         = (count_q == CW'(DEPTH));
    assign head         = mem_q[rptr_q];

    // A pop only ever drains a stored entry; a bypassed entry is not in mem.
    assign pop = stored_valid && rq.out_ready;

`ifdef READQ_BYPASS_EN
    assign byp_take = rq.push && !reset && !stored_valid && rq.out_ready;
`else
    assign byp_take = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign wr_en = rq.push && !reset && (!full || pop) && !byp_take;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) wptr_d = wptr_q + AW'(1);
        if (pop)   rptr_d = rptr_q + AW'(1);
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (rq.push && full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wptr_q] <= {rq.push_data, rq.push_tag};
    end

    // Output view: stored head when occupied, optional bypass when empty,
    // zeros otherwise.
    always_comb begin
        rq.out_valid = stored_valid;
        rq.out_data  = '0;
        rq.out_tag   = '0;
        if (stored_valid) begin
            rq.out_data = head[EW-1:TWIDTH];
            rq.out_tag  = head[TWIDTH-1:0];
        end
`ifdef READQ_BYPASS_EN
        else if (rq.push && !reset) begin
            rq.out_valid = 1'b1;
            rq.out_data  = rq.push_data;
            rq.out_tag   = rq.push_tag;
        end
`endif
    end

    assign rq.count       = count_q;
    assign rq.full        = full;
    assign rq.almost_full = (count_q >= CW'(AFULL_LEVEL));
    assign rq.overflow    = overflow_q;
endmodule
